// File: rtl/lpf_iir1_mc.sv
// Time-multiplexed first-order IIR lowpass filter.
// H(z) = (1 + z^-1) / (2^(K+1) * (1 - (1 - 2^-K) z^-1)), unity DC gain.
// N channels share one datapath; per-channel state lives in registers so a
// sample on the same channel in the next cycle sees the freshly written state.
module lpf_iir1_mc #(
  parameter int W    = 13,
  parameter int CH   = 4,
  parameter int KMAX = 6,
  parameter int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic [2:0]          k_sel,
  input  logic                in_valid,
  input  logic [CW-1:0]       in_ch,
  input  logic signed [W-1:0] in_data,
  output logic                out_valid,
  output logic [CW-1:0]       out_ch,
  output logic signed [W-1:0] out_data,
  output logic                err_ch
);

  // Accumulator width: W bits of signal, KMAX+1 bits of gain, one guard bit.
  localparam int SW = W + KMAX + 2;

  localparam logic [CW:0]          CH_LIM = (CW + 1)'(CH);
  localparam logic [2:0]           K_MAX  = 3'(KMAX);
  localparam logic signed [SW-1:0] Y_MAX  = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [SW-1:0] Y_MIN  = ~Y_MAX;

  logic signed [SW-1:0] s_arr  [CH];
  logic signed [W-1:0]  x1_arr [CH];

  logic                 ch_ok;
  logic                 accept;
  logic [2:0]           k_eff;
  logic [3:0]           k_out;
  logic signed [SW-1:0] s_rd;
  logic signed [W-1:0]  x1_rd;
  logic signed [SW-1:0] x_ext;
  logic signed [SW-1:0] x1_ext;
  logic signed [SW-1:0] s_next;
  logic signed [SW-1:0] y_full;
  logic signed [W-1:0]  y_sat;

  assign ch_ok  = ({1'b0, in_ch} < CH_LIM);
  assign accept = in_valid & ch_ok & ~clr;

  // Clamp the requested cutoff shift into 1..KMAX.
  always_comb begin
    k_eff = k_sel;
    if (k_sel == 3'd0) begin
      k_eff = 3'd1;
    end else if (k_sel > K_MAX) begin
      k_eff = K_MAX;
    end
  end

  assign k_out = {1'b0, k_eff} + 4'd1;

  // Select the state of the addressed channel; out-of-range channels read zero.
  always_comb begin
    s_rd  = '0;
    x1_rd = '0;
    for (int i = 0; i < CH; i++) begin
      if (in_ch == CW'(i)) begin
        s_rd  = s_arr[i];
        x1_rd = x1_arr[i];
      end
    end
  end

  assign x_ext  = {{(SW - W){in_data[W-1]}}, in_data};
  assign x1_ext = {{(SW - W){x1_rd[W-1]}}, x1_rd};

  // Shared datapath: leaky accumulator update, output scaling and saturation.
  always_comb begin
    s_next = s_rd + x_ext + x1_ext - (s_rd >>> k_eff);
    y_full = s_next >>> k_out;
    if (y_full > Y_MAX) begin
      y_sat = Y_MAX[W-1:0];
    end else if (y_full < Y_MIN) begin
      y_sat = Y_MIN[W-1:0];
    end else begin
      y_sat = y_full[W-1:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : gen_ch
      logic signed [SW-1:0] s_reg;
      logic signed [W-1:0]  x1_reg;
      logic                 wr;

      assign wr = accept && (in_ch == CW'(gi));

      // Per-channel state: zeroed by reset or clear, updated only when addressed.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          s_reg  <= '0;
          x1_reg <= '0;
        end else if (wr) begin
          s_reg  <= s_next;
          x1_reg <= in_data;
        end
      end

      assign s_arr[gi]  = s_reg;
      assign x1_arr[gi] = x1_reg;
    end
  endgenerate

  // Registered outputs; data and channel hold while no result is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      err_ch    <= 1'b0;
    end else begin
      out_valid <= accept;
      err_ch    <= in_valid & ~ch_ok & ~clr;
      if (accept) begin
        out_ch   <= in_ch;
        out_data <= y_sat;
      end
    end
  end

endmodule
